rx_fifo_packer: RTL and testbench
=================================

# rx_fifo_packer

Receive-side FIFO write controller and word store: accepts a byte stream from the USB/serial receive path, packs bytes little-endian into 32-bit words, and enqueues each completed (or flushed partial) word with its valid-byte count. The reader (AHB slave side) dequeues whole words. It is the receive counterpart of the transmit FIFO state machine, which unpacks words into bytes.

## Interface
- DEPTH, 8, number of word entries; power of two, 2..64
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- rx_byte_valid  input  1  rx_byte presented this cycle
- rx_byte  input  8  received byte
- rx_flush  input  1  end of packet; commit any partial word
- rx_ready  output  1  byte accepted this cycle if rx_byte_valid
- rd_deq_word  input  1  reader pops head entry
- rd_data  output  32  head word (show-ahead)
- rd_bytes  output  3  valid bytes in head word, 1..4
- empty  output  1  no entries
- full  output  1  DEPTH entries held
- count  output  $clog2(DEPTH)+1  entries held
- overflow  output  1  sticky: byte offered while rx_ready=0

## Operation
- Reset: state IDLE, tail_side=0, pack register 0, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rx_ready=1, overflow=0, rd_data=0, rd_bytes=0.
- tail_side (2 bits) = lane for next byte; byte k of a word at bits [8k+7:8k].
- rx_ready = !full && state != FLUSH_WAIT.
- Accepted byte (rx_byte_valid && rx_ready): written to lane tail_side; if tail_side==3, word (rd_bytes=4) committed at wr_ptr, tail_side->0, wr_ptr++; else tail_side++.
- rx_flush with partial word (tail_side!=0 after any same-cycle byte): commit pack register, unused lanes zero, bytes=tail_side; tail_side->0. If the same-cycle byte completed the word, exactly one 4-byte commit occurs.
- rx_flush with tail_side==0 and nothing pending: no-op.
- rx_flush with partial word while full: enter FLUSH_WAIT; commit on first cycle full=0, then IDLE.
- rx_byte_valid while rx_ready=0: byte dropped, overflow set until rst.
- States: IDLE (tail_side=0) -> PACK on accepted byte with tail_side 0..2 result nonzero; PACK -> IDLE on commit (lane 3 or flush); PACK -> FLUSH_WAIT on flush while full; FLUSH_WAIT -> IDLE on commit.
- rd_deq_word when empty: ignored. Dequeue: rd_ptr++.
- Simultaneous commit and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count saturates impossible by construction.

## Timing
- rd_data/rd_bytes combinational from head entry; 0 when empty.
- Commit on edge N: empty deasserts, count increments, rd_data valid after edge N.
- Dequeue on edge N: next entry (or empty) visible after edge N.
- full deassertion after a dequeue on edge N allows byte acceptance in cycle N+1 (no combinational rd_deq_word -> rx_ready path).
- rst mid-packet: partial word and all entries discarded next edge.

## Structure
- Package rx_fifo_pkg: state enum (IDLE, PACK, FLUSH_WAIT), WORD_BYTES=4, BYTE_W=8.
- Sub-module rx_fifo_mem: DEPTH x 35-bit storage (32 data + 3 byte count), one write port, asynchronous read port, no reset on array.
- Top: FSM, packer, pointers, count, flags.

## Test plan
- Bytes 0x11,0x22,0x33,0x44 -> one entry, rd_data=0x44332211, rd_bytes=4, empty=0 after 4th edge.
- Bytes 0xAA,0xBB then rx_flush -> rd_data=0x0000BBAA, rd_bytes=2; flush with tail_side=0 -> count unchanged.
- Byte 0x44 at lane 3 with rx_flush same cycle -> exactly one entry, rd_bytes=4.
- Fill DEPTH=8 words -> full=1, rx_ready=0; extra byte -> overflow=1, dropped; dequeue + commit same cycle at count=5 -> count stays 5.
- Partial word held while full, rx_flush -> FLUSH_WAIT; one dequeue -> partial committed next cycle, state IDLE, rx_ready=1.
- rst asserted with 2 bytes packed and 3 entries -> next cycle count=0, empty=1, tail_side=0, overflow=0.

Source files
------------

// File: rtl/rx_fifo_packer_pkg.sv
// Shared types and constants for the receive FIFO packer.
// Entries carry a packed little-endian word plus its valid-byte count.
package rx_fifo_pkg;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_W     = 8;
   localparam int WORD_W     = WORD_BYTES * BYTE_W;
   localparam int BCNT_W     = 3;
   localparam int ENTRY_W    = WORD_W + BCNT_W;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PACK       = 2'd1,
      FLUSH_WAIT = 2'd2
   } state_t;

   typedef struct packed {
      logic [BCNT_W-1:0] bytes;
      logic [WORD_W-1:0] data;
   } entry_t;

   function automatic logic [WORD_W-1:0] lane_insert(
      input logic [WORD_W-1:0] word,
      input logic [1:0]        lane,
      input logic [BYTE_W-1:0] b
   );
      logic [WORD_W-1:0] r;
      r = word;
      r[lane*BYTE_W +: BYTE_W] = b;
      return r;
   endfunction

endpackage

// File: rtl/rx_fifo_packer_if.sv
// Byte-in / word-out bus of the receive FIFO packer.
// master drives bytes and dequeues; slave is the packer itself.
interface rx_fifo_packer_if #(parameter int DEPTH = 8);
   import rx_fifo_pkg::*;

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic                rx_byte_valid;
   logic [BYTE_W-1:0]   rx_byte;
   logic                rx_flush;
   logic                rx_ready;
   logic                rd_deq_word;
   logic [WORD_W-1:0]   rd_data;
   logic [BCNT_W-1:0]   rd_bytes;
   logic                empty;
   logic                full;
   logic [CNT_W-1:0]    count;
   logic                overflow;

   modport master (
      output rx_byte_valid, rx_byte, rx_flush, rd_deq_word,
      input  rx_ready, rd_data, rd_bytes, empty, full, count, overflow
   );

   modport slave (
      input  rx_byte_valid, rx_byte, rx_flush, rd_deq_word,
      output rx_ready, rd_data, rd_bytes, empty, full, count, overflow
   );

endinterface

// File: rtl/rx_fifo_packer_mem.sv
// Word store for the receive FIFO: one write port, asynchronous read.
// The array is deliberately unreset; pointers and count define validity.
module rx_fifo_mem
   import rx_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  entry_t        wdata,
   input  logic [AW-1:0] raddr,
   output entry_t        rdata
);

   entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo_packer.sv
// Receive FIFO write controller: packs bytes little-endian into words and
// enqueues full or flushed partial words; the reader pops whole words.
//
// state      | meaning
// IDLE       | no bytes pending in the pack register (tail_side = 0)
// PACK       | 1..3 bytes pending in the pack register
// FLUSH_WAIT | flush requested while full; commit when space frees up
module rx_fifo_packer
   import rx_fifo_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   rx_fifo_packer_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   state_t            state;
   logic [1:0]        tail_side;
   logic [WORD_W-1:0] pack;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              overflow;

   logic              full;
   logic              empty;
   logic              rx_ready;
   logic              accept;
   logic              deq;
   logic              commit;
   logic              to_wait;
   logic [1:0]        next_tail;
   logic [WORD_W-1:0] next_pack;
   entry_t            commit_entry;
   entry_t            head;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign rx_ready = !full && (state != FLUSH_WAIT);
   assign accept   = bus.rx_byte_valid && rx_ready;
   assign deq      = bus.rd_deq_word && !empty;

   // Unused lanes of the pack register stay zero because it clears on commit.
   always_comb begin
      next_pack          = accept ? lane_insert(pack, tail_side, bus.rx_byte) : pack;
      next_tail          = accept ? tail_side + 2'd1 : tail_side;
      commit             = 1'b0;
      to_wait            = 1'b0;
      commit_entry.data  = next_pack;
      commit_entry.bytes = {1'b0, next_tail};
      if (state == FLUSH_WAIT) begin
         if (!full) begin
            commit = 1'b1;
         end
      end else if (accept && (tail_side == 2'd3)) begin
         commit             = 1'b1;
         commit_entry.bytes = 3'd4;
      end else if (bus.rx_flush && (next_tail != 2'd0)) begin
         if (full) begin
            to_wait = 1'b1;
         end else begin
            commit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tail_side <= 2'd0;
         pack      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
      end else begin
         if (bus.rx_byte_valid && !rx_ready) begin
            overflow <= 1'b1;
         end

         if (commit) begin
            wr_ptr    <= wr_ptr + 1'b1;
            tail_side <= 2'd0;
            pack      <= '0;
            state     <= IDLE;
         end else begin
            tail_side <= next_tail;
            pack      <= next_pack;
            case (state)
               IDLE:       if (accept)  state <= PACK;
               PACK:       if (to_wait) state <= FLUSH_WAIT;
               FLUSH_WAIT: state <= FLUSH_WAIT;
               default:    state <= IDLE;
            endcase
         end

         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({commit, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (commit),
      .waddr (wr_ptr),
      .wdata (commit_entry),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign bus.rx_ready = rx_ready;
   assign bus.rd_data  = empty ? '0 : head.data;
   assign bus.rd_bytes = empty ? '0 : head.bytes;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count    = count;
   assign bus.overflow = overflow;

endmodule

// File: tb/tb_rx_fifo_packer.sv
// Scoreboard bench for rx_fifo_packer: a byte-list reference model predicts
// committed words and flags; a negedge monitor checks every dequeued word.
module tb_rx_fifo_packer;
   import rx_fifo_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rx_fifo_packer_if #(.DEPTH(DEPTH)) bus();

   rx_fifo_packer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      int          bytes;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        exp_q[$];

   int          m_cnt = 0;
   byte unsigned m_part[$];
   bit          m_fw  = 1'b0;
   bit          m_ovf = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_commit();
      exp_t e;
      e.data = 32'h0;
      foreach (m_part[i]) e.data |= 32'(m_part[i]) << (8 * i);
      e.bytes = m_part.size();
      exp_q.push_back(e);
      m_part.delete();
   endfunction

   // Called at posedge+1: checks flags for this cycle, drives inputs, advances model.
   task automatic step(input bit v, input byte unsigned b, input bit f, input bit d, input bit r = 1'b0);
      bit ready;
      int commits;
      ready = (m_cnt < DEPTH) && !m_fw;
      chk("rx_ready", bus.rx_ready, ready);
      chk("count", bus.count, m_cnt);
      chk("empty", bus.empty, m_cnt == 0);
      chk("full", bus.full, m_cnt == DEPTH);
      chk("overflow", bus.overflow, m_ovf);

      bus.rx_byte_valid = v;
      bus.rx_byte       = b;
      bus.rx_flush      = f;
      bus.rd_deq_word   = d;
      rst               = r;

      if (r) begin
         m_cnt = 0;
         m_part.delete();
         m_fw  = 1'b0;
         m_ovf = 1'b0;
         exp_q.delete();
      end else begin
         commits = 0;
         if (v && !ready) m_ovf = 1'b1;
         if (m_fw) begin
            if (m_cnt < DEPTH) begin
               model_commit();
               commits = 1;
               m_fw = 1'b0;
            end
         end else begin
            if (v && ready) begin
               m_part.push_back(b);
               if (m_part.size() == 4) begin
                  model_commit();
                  commits++;
               end
            end
            if (f && m_part.size() != 0) begin
               if (m_cnt == DEPTH) m_fw = 1'b1;
               else begin
                  model_commit();
                  commits++;
               end
            end
         end
         if (d && m_cnt > 0) m_cnt--;
         m_cnt += commits;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.rd_deq_word && !bus.empty) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL deq_unexpected: got %0h/%0d expected no entry", bus.rd_data, bus.rd_bytes);
            end else begin
               e = exp_q.pop_front();
               chk("rd_data", bus.rd_data, e.data);
               chk("rd_bytes", bus.rd_bytes, e.bytes);
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bus.rx_byte_valid = 1'b0;
      bus.rx_byte       = 8'h00;
      bus.rx_flush      = 1'b0;
      bus.rd_deq_word   = 1'b0;
      @(posedge clk);
      #1;
      step(0, 8'h00, 0, 0, 1);
      chk("reset_rd_data", bus.rd_data, 32'h0);
      chk("reset_rd_bytes", bus.rd_bytes, 3'd0);

      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      chk("word4_data", bus.rd_data, 32'h44332211);
      chk("word4_bytes", bus.rd_bytes, 3'd4);
      chk("word4_empty", bus.empty, 1'b0);
      step(0, 8'h00, 0, 1);

      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 0, 0);
      step(0, 8'h00, 1, 0);
      chk("partial_data", bus.rd_data, 32'h0000BBAA);
      chk("partial_bytes", bus.rd_bytes, 3'd2);
      step(0, 8'h00, 1, 0);
      chk("empty_flush_count", bus.count, 1);
      step(0, 8'h00, 0, 1);

      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 1, 0);
      chk("lane3_flush_count", bus.count, 1);
      chk("lane3_flush_bytes", bus.rd_bytes, 3'd4);
      step(0, 8'h00, 0, 1);

      for (int i = 0; i < 4 * DEPTH; i++) step(1, 8'(i + 1), 0, 0);
      chk("fill_full", bus.full, 1'b1);
      chk("fill_ready", bus.rx_ready, 1'b0);
      step(1, 8'hEE, 0, 0);
      chk("overflow_set", bus.overflow, 1'b1);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);
      step(1, 8'hC1, 0, 0);
      step(1, 8'hC2, 0, 0);
      step(1, 8'hC3, 0, 0);
      step(1, 8'hC4, 0, 1);
      chk("commit_deq_count", bus.count, 5);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 0, 1);

      for (int i = 0; i < 14; i++) step(1, 8'(8'h30 + i), 0, 0);
      step(0, 8'h00, 0, 0, 1);
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1'b1);
      chk("rst_overflow", bus.overflow, 1'b0);
      step(1, 8'h5A, 1, 0);
      chk("rst_fresh_data", bus.rd_data, 32'h0000005A);
      chk("rst_fresh_bytes", bus.rd_bytes, 3'd1);
      step(0, 8'h00, 0, 1);

      for (int i = 0; i < 1500; i++) begin
         int dprob;
         dprob = ((i / 200) % 2 == 1) ? 70 : 15;
         step(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0,
              ($urandom % 100) < dprob, ($urandom % 500) == 0);
      end

      step(0, 8'h00, 1, 0);
      for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
